cnn_stream_conv_pool: RTL and testbench
=======================================

Name: cnn_stream_conv_pool

Overview:
- Next-generation convolution core for the CNN datapath.
- Frames stream in one pixel per cycle over a valid/ready port. Weights for all features are held internally.
- The core runs a strided KxK convolution for every feature, applies a saturating ReLU, then max-pools.
- Pooled results stream out feature-major, in flattened order, over a backpressured valid/ready port to the dense stage.

Parameters:
- IMAGE_WIDTH, 12, input frame width in pixels
- IMAGE_HEIGHT, 12, input frame height in pixels
- KERNEL_SIZE, 3, convolution kernel edge
- NUM_FEATURES, 2, number of feature kernels computed in parallel
- PIX_WIDTH, 2, signed pixel width
- WEIGHT_WIDTH, 2, signed weight width
- DATA_WIDTH, 8, unsigned width of the ReLU/pool output
- STRIDE, 1, convolution stride (>=1, any integer)
- POOL_SIZE, 2, max-pool window edge and pool stride
- Derived: CONV_W=(IMAGE_WIDTH-KERNEL_SIZE)/STRIDE+1; CONV_H likewise; POOL_W=CONV_W/POOL_SIZE and POOL_H=CONV_H/POOL_SIZE (floor; partial windows dropped); ACC_W=PIX_WIDTH+WEIGHT_WIDTH+$clog2(KERNEL_SIZE*KERNEL_SIZE)

Ports:
- clk  in  1  rising-edge clock
- rst_cnn  in  1  reset, asynchronous, active-low
- wt_wr_en  in  1  weight write strobe, active-high
- wt_feature  in  $clog2(NUM_FEATURES)+1  target feature index
- wt_data  in  KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH  packed weights, element 0 (top-left) in the LSBs, raster order
- pix_valid  in  1  pixel valid
- pix_ready  out  1  pixel accept
- pix_data  in  PIX_WIDTH  signed pixel, raster order
- out_valid  out  1  pooled result valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_WIDTH  pooled value
- out_feature  out  $clog2(NUM_FEATURES)+1  feature index of out_data
- out_last  out  1  final beat of the frame
- busy  out  1  high whenever state != IDLE
- frame_done  out  1  one-cycle pulse after the last output handshake

Behaviour:
- Reset (rst_cnn low, async):
  - state=IDLE; all counters 0; all weights 0.
  - out_valid=0, out_last=0, out_data=0, out_feature=0, frame_done=0, busy=0, pix_ready=1.
  - Frame and pool buffers are not cleared.
  - Reset mid-operation aborts the frame immediately; no further output beats.
- Handshake rule: a transfer occurs on a rising edge with valid&&ready.
  - While out_valid=1 and out_ready=0, out_data, out_feature and out_last hold stable.
  - out_valid never drops without a handshake, except on reset.
- States:
  - IDLE: pix_ready=1. An accepted pixel is written to frame[0][0] and moves the FSM to LOAD with the pixel count at 1.
  - LOAD: pix_ready=1. Each accepted pixel is written in raster order. On acceptance of pixel IMAGE_WIDTH*IMAGE_HEIGHT-1, go to CONV; pix_ready=0 from the next cycle.
  - CONV:
    - One output position per cycle, raster over CONV_H x CONV_W; window origin is (row*STRIDE, col*STRIDE).
    - Per feature, the full-precision signed sum over KxK of pixel*weight is computed in ACC_W bits.
    - ReLU: a sum <0 gives 0; a sum >2^DATA_WIDTH-1 saturates to 2^DATA_WIDTH-1; otherwise the low DATA_WIDTH bits are kept.
    - Result is written to conv_map[f][row][col].
    - After the last position (CONV_H*CONV_W cycles), go to POOL.
  - POOL:
    - One pooled position per cycle, raster over POOL_H x POOL_W, all features in parallel.
    - Each result is the unsigned max of its POOL_SIZE x POOL_SIZE window, written to pool_map. Ties are irrelevant (value only).
    - After POOL_H*POOL_W cycles, go to EMIT.
  - EMIT:
    - Beats are issued in order f=0..NUM_FEATURES-1, then row, then col.
    - out_last=1 only on beat NUM_FEATURES*POOL_H*POOL_W-1.
    - On the last handshake: out_valid=0, frame_done pulses for 1 cycle, and the FSM returns to IDLE.
- Weight writes:
  - Accepted on a clock edge with wt_wr_en=1 in IDLE, LOAD, POOL or EMIT.
  - Ignored in CONV.
  - Ignored if wt_feature>=NUM_FEATURES.
  - The write takes effect from the next cycle.
- Latency:
  - First output is valid exactly CONV_H*CONV_W + POOL_H*POOL_W cycles after the last pixel is accepted.
  - Throughput is 1 beat/cycle when out_ready=1.
- Simultaneous events: a pixel offered while in CONV, POOL or EMIT is not accepted (pix_ready=0). No new frame may start until IDLE.

Decomposition:
- Package cnn_pkg:
  - state enum (IDLE, LOAD, CONV, POOL, EMIT)
  - constant functions for CONV_W/H, POOL_W/H and ACC_W
  - function sat_relu(acc) returning DATA_WIDTH
- Sub-module cnn_window_mac: combinational KxK signed MAC for one feature (window, weights -> ACC_W sum), instantiated NUM_FEATURES times.

Test Plan:
- Reset with defaults -> out_valid=0, busy=0, pix_ready=1, frame_done=0; assert rst_cnn during LOAD -> FSM returns to IDLE and pix_ready stays 1.
- Defaults; f0 weights all +1, f1 all -1; 144 pixels of +1 -> 50 beats: 25 beats f0 value 9, then 25 beats f1 value 0; out_last only on beat 49; frame_done pulses once.
- Defaults; image all -2, weights all -2 -> every f0 beat = 36. Instance DATA_WIDTH=5, same stimulus -> every beat = 31 (saturation).
- Defaults; out_ready pattern 1,0,0,1 repeating, plus pix_valid gaps -> all 50 beats in order; data/feature/last stable while stalled; first valid 125 cycles after the last pixel with out_ready=1.
- STRIDE=2 instance (CONV 5x5, POOL 2x2, 8 beats); pixel(0,0)=1, others 0; f0 weight[0]=1, others 0 -> f0 beats 1,0,0,0; f1 beats 0,0,0,0.
- Weight write to f0 (all +1) during CONV -> ignored, frame uses the old weights. Same write in EMIT -> next frame uses the new weights. rst_cnn low after beat 10 -> out_valid drops immediately; the next frame emits all 50 beats.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and elaboration-time helpers for the streaming convolution/pool core.
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CONV,
        POOL,
        EMIT
    } cnn_state_t;

    function automatic int conv_dim(input int img, input int k, input int s);
        return (img - k) / s + 1;
    endfunction

    // Partial pool windows at the right/bottom edge are dropped.
    function automatic int pool_dim(input int conv, input int p);
        return conv / p;
    endfunction

    function automatic int acc_width(input int pw, input int ww, input int k);
        return pw + ww + $clog2(k * k);
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Clamp a signed accumulator into [0, 2^dw-1]; caller truncates to dw bits.
    function automatic logic [31:0] sat_relu(input logic signed [31:0] acc, input int dw);
        logic signed [31:0] lim;
        lim = (32'sd1 <<< dw) - 32'sd1;
        if (acc < 0)
            return '0;
        if (acc > lim)
            return lim;
        return acc;
    endfunction

endpackage

// File: rtl/cnn_window_mac.sv
// Combinational KxK signed multiply-accumulate for one feature kernel.
module cnn_window_mac #(
    parameter int KERNEL_SIZE  = 3,
    parameter int PIX_WIDTH    = 2,
    parameter int WEIGHT_WIDTH = 2,
    parameter int ACC_W        = 8
) (
    input  logic [KERNEL_SIZE*KERNEL_SIZE*PIX_WIDTH-1:0]    win,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH-1:0] wts,
    output logic signed [ACC_W-1:0]                         acc
);

    localparam int KK = KERNEL_SIZE * KERNEL_SIZE;

    always_comb begin
        acc = '0;
        for (int i = 0; i < KK; i++) begin
            acc = acc + ACC_W'($signed(win[i*PIX_WIDTH +: PIX_WIDTH]))
                      * ACC_W'($signed(wts[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
        end
    end

endmodule

// File: rtl/cnn_stream_conv_pool.sv
// Frame-buffered strided convolution, saturating ReLU and max-pool for NUM_FEATURES
// kernels, emitting pooled maps feature-major over a backpressured stream.
module cnn_stream_conv_pool
    import cnn_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 12,
    parameter int IMAGE_HEIGHT = 12,
    parameter int KERNEL_SIZE  = 3,
    parameter int NUM_FEATURES = 2,
    parameter int PIX_WIDTH    = 2,
    parameter int WEIGHT_WIDTH = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int STRIDE       = 1,
    parameter int POOL_SIZE    = 2
) (
    input  logic                                           clk,
    input  logic                                           rst_cnn,
    input  logic                                           wt_wr_en,
    input  logic [$clog2(NUM_FEATURES):0]                  wt_feature,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH-1:0] wt_data,
    input  logic                                           pix_valid,
    output logic                                           pix_ready,
    input  logic [PIX_WIDTH-1:0]                           pix_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [DATA_WIDTH-1:0]                          out_data,
    output logic [$clog2(NUM_FEATURES):0]                  out_feature,
    output logic                                           out_last,
    output logic                                           busy,
    output logic                                           frame_done
);

    localparam int CONV_W = conv_dim(IMAGE_WIDTH, KERNEL_SIZE, STRIDE);
    localparam int CONV_H = conv_dim(IMAGE_HEIGHT, KERNEL_SIZE, STRIDE);
    localparam int POOL_W = pool_dim(CONV_W, POOL_SIZE);
    localparam int POOL_H = pool_dim(CONV_H, POOL_SIZE);
    localparam int ACC_W  = acc_width(PIX_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE);
    localparam int KK     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int FW     = $clog2(NUM_FEATURES) + 1;
    localparam int XW     = idx_w(IMAGE_WIDTH);
    localparam int YW     = idx_w(IMAGE_HEIGHT);
    localparam int CXW    = idx_w(CONV_W);
    localparam int CYW    = idx_w(CONV_H);
    localparam int PXW    = idx_w(POOL_W);
    localparam int PYW    = idx_w(POOL_H);
    localparam int FIW    = idx_w(NUM_FEATURES);
    localparam int TOTAL_BEATS = NUM_FEATURES * POOL_H * POOL_W;

    logic signed [PIX_WIDTH-1:0] frame    [IMAGE_HEIGHT][IMAGE_WIDTH];
    logic [DATA_WIDTH-1:0]       conv_map [NUM_FEATURES][CONV_H][CONV_W];
    logic [DATA_WIDTH-1:0]       pool_map [NUM_FEATURES][POOL_H][POOL_W];
    logic [KK*WEIGHT_WIDTH-1:0]  weights  [NUM_FEATURES];

    cnn_state_t     state;
    logic [XW-1:0]  ld_x;
    logic [YW-1:0]  ld_y;
    logic [CXW-1:0] cv_x;
    logic [CYW-1:0] cv_y;
    logic [PXW-1:0] pl_x, em_x, nxt_x;
    logic [PYW-1:0] pl_y, em_y, nxt_y;
    logic [FIW-1:0] em_f, nxt_f;
    logic           nxt_last;

    logic [KK*PIX_WIDTH-1:0]  win;
    logic signed [ACC_W-1:0]  acc  [NUM_FEATURES];
    logic [DATA_WIDTH-1:0]    relu [NUM_FEATURES];
    logic [DATA_WIDTH-1:0]    pmax [NUM_FEATURES];
    logic [DATA_WIDTH-1:0]    cand;
    logic [DATA_WIDTH-1:0]    first_beat;

    logic pix_fire;

    assign pix_ready = (state == IDLE) || (state == LOAD);
    assign busy      = (state != IDLE);
    assign pix_fire  = pix_valid && pix_ready;

    // Window origin advances by STRIDE per output position.
    always_comb begin
        win = '0;
        for (int ky = 0; ky < KERNEL_SIZE; ky++) begin
            for (int kx = 0; kx < KERNEL_SIZE; kx++) begin
                win[(ky*KERNEL_SIZE+kx)*PIX_WIDTH +: PIX_WIDTH] =
                    frame[YW'(int'(cv_y)*STRIDE+ky)][XW'(int'(cv_x)*STRIDE+kx)];
            end
        end
    end

    for (genvar f = 0; f < NUM_FEATURES; f++) begin : g_mac
        cnn_window_mac #(
            .KERNEL_SIZE (KERNEL_SIZE),
            .PIX_WIDTH   (PIX_WIDTH),
            .WEIGHT_WIDTH(WEIGHT_WIDTH),
            .ACC_W       (ACC_W)
        ) u_mac (
            .win(win),
            .wts(weights[f]),
            .acc(acc[f])
        );
    end

    always_comb begin
        for (int f = 0; f < NUM_FEATURES; f++)
            relu[f] = DATA_WIDTH'(sat_relu(32'(acc[f]), DATA_WIDTH));
    end

    always_comb begin
        cand = '0;
        for (int f = 0; f < NUM_FEATURES; f++) begin
            pmax[f] = '0;
            for (int py = 0; py < POOL_SIZE; py++) begin
                for (int px = 0; px < POOL_SIZE; px++) begin
                    cand = conv_map[f][CYW'(int'(pl_y)*POOL_SIZE+py)][CXW'(int'(pl_x)*POOL_SIZE+px)];
                    if (cand > pmax[f])
                        pmax[f] = cand;
                end
            end
        end
    end

    // A single-position pool map is still being written when EMIT starts.
    assign first_beat = (POOL_H * POOL_W == 1) ? pmax[0] : pool_map[0][0][0];

    always_comb begin
        nxt_f = em_f;
        nxt_y = em_y;
        nxt_x = em_x + 1'b1;
        if (em_x == PXW'(POOL_W-1)) begin
            nxt_x = '0;
            nxt_y = em_y + 1'b1;
            if (em_y == PYW'(POOL_H-1)) begin
                nxt_y = '0;
                nxt_f = em_f + 1'b1;
            end
        end
        nxt_last = (nxt_f == FIW'(NUM_FEATURES-1)) && (nxt_y == PYW'(POOL_H-1))
                && (nxt_x == PXW'(POOL_W-1));
    end

    // Frame and map storage survive reset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (pix_fire)
            frame[ld_y][ld_x] <= pix_data;
        if (state == CONV) begin
            for (int f = 0; f < NUM_FEATURES; f++)
                conv_map[f][cv_y][cv_x] <= relu[f];
        end
        if (state == POOL) begin
            for (int f = 0; f < NUM_FEATURES; f++)
                pool_map[f][pl_y][pl_x] <= pmax[f];
        end
    end

    always_ff @(posedge clk or negedge rst_cnn) begin
        if (!rst_cnn) begin
            state       <= IDLE;
            ld_x        <= '0;
            ld_y        <= '0;
            cv_x        <= '0;
            cv_y        <= '0;
            pl_x        <= '0;
            pl_y        <= '0;
            em_x        <= '0;
            em_y        <= '0;
            em_f        <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            out_feature <= '0;
            frame_done  <= 1'b0;
            for (int f = 0; f < NUM_FEATURES; f++)
                weights[f] <= '0;
        end else begin
            frame_done <= 1'b0;
            if (wt_wr_en && state != CONV && int'(wt_feature) < NUM_FEATURES)
                weights[wt_feature[FIW-1:0]] <= wt_data;

            case (state)
                IDLE, LOAD: begin
                    if (pix_fire) begin
                        state <= LOAD;
                        if (ld_x == XW'(IMAGE_WIDTH-1)) begin
                            ld_x <= '0;
                            if (ld_y == YW'(IMAGE_HEIGHT-1)) begin
                                ld_y  <= '0;
                                state <= CONV;
                            end else begin
                                ld_y <= ld_y + 1'b1;
                            end
                        end else begin
                            ld_x <= ld_x + 1'b1;
                        end
                    end
                end
                CONV: begin
                    if (cv_x == CXW'(CONV_W-1)) begin
                        cv_x <= '0;
                        if (cv_y == CYW'(CONV_H-1)) begin
                            cv_y  <= '0;
                            state <= POOL;
                        end else begin
                            cv_y <= cv_y + 1'b1;
                        end
                    end else begin
                        cv_x <= cv_x + 1'b1;
                    end
                end
                POOL: begin
                    if (pl_x == PXW'(POOL_W-1)) begin
                        pl_x <= '0;
                        if (pl_y == PYW'(POOL_H-1)) begin
                            pl_y        <= '0;
                            state       <= EMIT;
                            out_valid   <= 1'b1;
                            out_data    <= first_beat;
                            out_feature <= '0;
                            out_last    <= (TOTAL_BEATS == 1);
                        end else begin
                            pl_y <= pl_y + 1'b1;
                        end
                    end else begin
                        pl_x <= pl_x + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= IDLE;
                            em_f       <= '0;
                            em_y       <= '0;
                            em_x       <= '0;
                        end else begin
                            em_f        <= nxt_f;
                            em_y        <= nxt_y;
                            em_x        <= nxt_x;
                            out_data    <= pool_map[nxt_f][nxt_y][nxt_x];
                            out_feature <= FW'(nxt_f);
                            out_last    <= nxt_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_stream_conv_pool.sv
// Self-checking bench: three core instances (default, 5-bit output, stride 2) against a
// plain-arithmetic convolution/ReLU/pool model.
module tb_cnn_stream_conv_pool;

    localparam int IW = 12;
    localparam int IH = 12;
    localparam int K  = 3;
    localparam int P  = 2;
    localparam int NF = 2;

    logic              clk;
    logic              rst_cnn;
    logic              wt_wr_en;
    logic [1:0]        wt_feature;
    logic [17:0]       wt_data;
    logic signed [1:0] pix_data;

    logic       pv [3];
    logic       pr [3];
    logic       ov [3];
    logic       ordy [3];
    logic       ol [3];
    logic       fd [3];
    logic       bz [3];
    logic [1:0] of [3];
    logic [7:0] od [3];
    logic [7:0] od0;
    logic [4:0] od1;
    logic [7:0] od2;

    assign od[0] = od0;
    assign od[1] = {3'b000, od1};
    assign od[2] = od2;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_acc = 0;

    int img [IW*IH];
    int wts [NF][K*K];
    logic [10:0] exp_q [$];

    cnn_stream_conv_pool u_dut0 (
        .clk(clk), .rst_cnn(rst_cnn), .wt_wr_en(wt_wr_en), .wt_feature(wt_feature),
        .wt_data(wt_data), .pix_valid(pv[0]), .pix_ready(pr[0]), .pix_data(pix_data),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0), .out_feature(of[0]),
        .out_last(ol[0]), .busy(bz[0]), .frame_done(fd[0])
    );

    cnn_stream_conv_pool #(.DATA_WIDTH(5)) u_dut1 (
        .clk(clk), .rst_cnn(rst_cnn), .wt_wr_en(wt_wr_en), .wt_feature(wt_feature),
        .wt_data(wt_data), .pix_valid(pv[1]), .pix_ready(pr[1]), .pix_data(pix_data),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1), .out_feature(of[1]),
        .out_last(ol[1]), .busy(bz[1]), .frame_done(fd[1])
    );

    cnn_stream_conv_pool #(.STRIDE(2)) u_dut2 (
        .clk(clk), .rst_cnn(rst_cnn), .wt_wr_en(wt_wr_en), .wt_feature(wt_feature),
        .wt_data(wt_data), .pix_valid(pv[2]), .pix_ready(pr[2]), .pix_data(pix_data),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2), .out_feature(of[2]),
        .out_last(ol[2]), .busy(bz[2]), .frame_done(fd[2])
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic write_raw(input int f, input logic [17:0] data);
        wt_wr_en   = 1'b1;
        wt_feature = 2'(f);
        wt_data    = data;
        tick();
        wt_wr_en   = 1'b0;
    endtask

    task automatic load_weights(input int f);
        logic [17:0] data;
        for (int i = 0; i < K*K; i++)
            data[i*2 +: 2] = 2'(wts[f][i]);
        write_raw(f, data);
    endtask

    task automatic fill_wts(input int f, input int v);
        for (int i = 0; i < K*K; i++)
            wts[f][i] = v;
    endtask

    task automatic random_image();
        for (int i = 0; i < IW*IH; i++)
            img[i] = int'($urandom_range(0, 3)) - 2;
    endtask

    task automatic random_weights();
        for (int f = 0; f < NF; f++)
            for (int i = 0; i < K*K; i++)
                wts[f][i] = int'($urandom_range(0, 3)) - 2;
    endtask

    function automatic int lat_of(input int s);
        int cw;
        int pw;
        cw = (IW - K) / s + 1;
        pw = cw / P;
        return cw * cw + pw * pw;
    endfunction

    // Reference: explicit sums of pixel*weight, clamp, then max over each pool window.
    task automatic build_expected(input int s, input int dw);
        int cw, pw, top, best, sum, v, r0, c0;
        cw  = (IW - K) / s + 1;
        pw  = cw / P;
        top = (1 << dw) - 1;
        for (int f = 0; f < NF; f++) begin
            for (int pr_i = 0; pr_i < pw; pr_i++) begin
                for (int pc_i = 0; pc_i < pw; pc_i++) begin
                    best = 0;
                    for (int py = 0; py < P; py++) begin
                        for (int px = 0; px < P; px++) begin
                            r0  = (pr_i * P + py) * s;
                            c0  = (pc_i * P + px) * s;
                            sum = 0;
                            for (int ky = 0; ky < K; ky++)
                                for (int kx = 0; kx < K; kx++)
                                    sum += img[(r0 + ky) * IW + c0 + kx] * wts[f][ky * K + kx];
                            v = (sum < 0) ? 0 : ((sum > top) ? top : sum);
                            if (v > best)
                                best = v;
                        end
                    end
                    exp_q.push_back({(f == NF-1 && pr_i == pw-1 && pc_i == pw-1), 2'(f), 8'(best)});
                end
            end
        end
    endtask

    task automatic send_frame(input int d, input bit gaps);
        bit pending;
        bit acc;
        int guard;
        for (int i = 0; i < IW*IH; i++) begin
            pending = 1'b1;
            guard   = 0;
            while (pending && guard < 50) begin
                pv[d]    = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                pix_data = 2'(img[i]);
                acc      = pv[d] && pr[d];
                tick();
                if (acc)
                    pending = 1'b0;
                guard++;
            end
            if (pending)
                check("pixel_accept_timeout", 32'(i), 32'(-1));
        end
        pv[d]    = 1'b0;
        last_acc = cyc;
    endtask

    task automatic collect(input int d, input int rmode, input int abort_at,
                           input bit emit_wr, input int lat);
        bit seen;
        bit hs;
        bit aborted;
        bit wr_done;
        int beats;
        int guard;
        int rpat;
        seen = 0; aborted = 0; wr_done = 0; beats = 0; guard = 0; rpat = 0;
        while (exp_q.size() > 0 && !aborted && guard < 3000) begin
            wt_wr_en = 1'b0;
            ordy[d]  = (rmode == 0) ? 1'b1 : ((rpat % 4 == 0) || (rpat % 4 == 3));
            rpat++;
            if (emit_wr && beats == 3 && !wr_done) begin
                wt_wr_en   = 1'b1;
                wt_feature = 2'd0;
                wt_data    = {9{2'b01}};
                wr_done    = 1'b1;
            end
            check("frame_done_early", 32'(fd[d]), 32'd0);
            if (ov[d]) begin
                if (!seen) begin
                    seen = 1'b1;
                    check("first_valid_latency", 32'(cyc - last_acc), 32'(lat));
                end
                check("beat", 32'({ol[d], of[d], od[d]}), 32'(exp_q[0]));
            end else if (seen) begin
                check("valid_held", 32'(ov[d]), 32'd1);
            end
            hs = ov[d] && ordy[d];
            tick();
            guard++;
            if (hs) begin
                void'(exp_q.pop_front());
                beats++;
                if (abort_at > 0 && beats == abort_at) begin
                    rst_cnn = 1'b0;
                    #1;
                    check("abort_valid", 32'(ov[d]), 32'd0);
                    check("abort_busy", 32'(bz[d]), 32'd0);
                    check("abort_pix_ready", 32'(pr[d]), 32'd1);
                    #2;
                    rst_cnn = 1'b1;
                    exp_q.delete();
                    aborted = 1'b1;
                end
            end
        end
        wt_wr_en = 1'b0;
        ordy[d]  = 1'b0;
        if (exp_q.size() != 0) begin
            check("emit_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end else if (aborted) begin
            for (int i = 0; i < 6; i++) begin
                tick();
                check("no_beats_after_reset", 32'(ov[d]), 32'd0);
            end
        end else begin
            check("valid_after_last", 32'(ov[d]), 32'd0);
            check("frame_done_pulse", 32'(fd[d]), 32'd1);
            tick();
            check("frame_done_width", 32'(fd[d]), 32'd0);
            check("idle_after_frame", 32'(bz[d]), 32'd0);
        end
    endtask

    initial begin
        rst_cnn    = 1'b0;
        wt_wr_en   = 1'b0;
        wt_feature = '0;
        wt_data    = '0;
        pix_data   = '0;
        for (int d = 0; d < 3; d++) begin
            pv[d]   = 1'b0;
            ordy[d] = 1'b0;
        end

        // Reset state
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            check("rst_out_valid", 32'(ov[d]), 32'd0);
            check("rst_busy", 32'(bz[d]), 32'd0);
            check("rst_pix_ready", 32'(pr[d]), 32'd1);
            check("rst_frame_done", 32'(fd[d]), 32'd0);
            check("rst_out_last", 32'(ol[d]), 32'd0);
            check("rst_out_data", 32'(od[d]), 32'd0);
            check("rst_out_feature", 32'(of[d]), 32'd0);
        end
        rst_cnn = 1'b1;
        tick();

        // Reset during LOAD returns to IDLE
        for (int i = 0; i < 20; i++) begin
            pv[0]    = 1'b1;
            pix_data = 2'sd1;
            tick();
        end
        pv[0] = 1'b0;
        check("load_busy", 32'(bz[0]), 32'd1);
        check("load_pix_ready", 32'(pr[0]), 32'd1);
        rst_cnn = 1'b0;
        #1;
        check("load_rst_busy", 32'(bz[0]), 32'd0);
        check("load_rst_pix_ready", 32'(pr[0]), 32'd1);
        #2;
        rst_cnn = 1'b1;
        tick();

        // f0 all +1, f1 all -1, image all +1
        fill_wts(0, 1);
        fill_wts(1, -1);
        load_weights(0);
        load_weights(1);
        for (int i = 0; i < IW*IH; i++) img[i] = 1;
        build_expected(1, 8);
        send_frame(0, 1'b0);
        collect(0, 0, -1, 1'b0, lat_of(1));

        // Image -2, weights -2: 36 at full width, saturated to 31 at 5 bits
        fill_wts(0, -2);
        fill_wts(1, -2);
        load_weights(0);
        load_weights(1);
        for (int i = 0; i < IW*IH; i++) img[i] = -2;
        build_expected(1, 8);
        send_frame(0, 1'b0);
        collect(0, 0, -1, 1'b0, lat_of(1));
        build_expected(1, 5);
        send_frame(1, 1'b0);
        collect(1, 0, -1, 1'b0, lat_of(1));

        // Random frame, pixel gaps, out_ready 1,0,0,1; out-of-range feature writes ignored
        random_image();
        random_weights();
        load_weights(0);
        load_weights(1);
        write_raw(2, {9{2'b01}});
        write_raw(3, {9{2'b10}});
        build_expected(1, 8);
        send_frame(0, 1'b1);
        collect(0, 1, -1, 1'b0, lat_of(1));

        // Stride 2: single hot pixel at (0,0)
        for (int i = 0; i < IW*IH; i++) img[i] = 0;
        img[0] = 1;
        fill_wts(0, 0);
        wts[0][0] = 1;
        fill_wts(1, -1);
        load_weights(0);
        load_weights(1);
        build_expected(2, 8);
        send_frame(2, 1'b0);
        collect(2, 0, -1, 1'b0, lat_of(2));

        // Stride 2: random frame with stalls
        random_image();
        random_weights();
        load_weights(0);
        load_weights(1);
        build_expected(2, 8);
        send_frame(2, 1'b1);
        collect(2, 1, -1, 1'b0, lat_of(2));

        // Weight write in CONV is ignored; the same write in EMIT applies to the next frame
        random_image();
        random_weights();
        fill_wts(0, -1);
        load_weights(0);
        load_weights(1);
        build_expected(1, 8);
        send_frame(0, 1'b0);
        check("in_conv_busy", 32'(bz[0]), 32'd1);
        write_raw(0, {9{2'b01}});
        collect(0, 0, -1, 1'b1, lat_of(1));
        fill_wts(0, 1);
        random_image();
        build_expected(1, 8);
        send_frame(0, 1'b0);
        collect(0, 1, 10, 1'b0, lat_of(1));

        // Full frame after the aborted one (weights were cleared by reset)
        random_image();
        random_weights();
        load_weights(0);
        load_weights(1);
        build_expected(1, 8);
        send_frame(0, 1'b1);
        collect(0, 1, -1, 1'b0, lat_of(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
